// File: rtl/processor_defs_pkg.sv
// Shared processor definitions: default widths, reset PC and the
// fetch-buffer entry layout {pc, data}. Used by the fetch unit, the RAM
// and the decoder.
package processor_defs_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;

    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    // Fetch-buffer entry: PC in the upper bits, instruction word below it.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] data;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(
        input logic [ADDR_W_DEF-1:0] pc,
        input logic [DATA_W_DEF-1:0] data
    );
        fetch_entry_t e;
        e.pc   = pc;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// ifu_fifo: synchronous prefetch FIFO, DEPTH x W, with flush.
// DEPTH must be a power of two so the pointers wrap naturally.
// Reset clears pointers, count and storage; flush clears pointers and
// count only (stale storage is never visible because empty masks it).
module ifu_fifo
    import processor_defs_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow; a pop frees the slot a full push needs.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head of queue and status flags.
    always_comb begin
        rdata = mem[rd_ptr];
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: drives the RAM fetch port from the fetch PC,
// buffers {pc, word} pairs in a prefetch FIFO and hands them to decode
// over valid/ready. Redirects flush the FIFO and reload the PC.
// Optional feature macro: IFU_PERF_EN adds saturating fetch/stall counters.
module instruction_fetch_unit
    import processor_defs_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              DATA_W   = DATA_W_DEF,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] fetch_address,
    input  logic [DATA_W-1:0] fetch_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
`ifdef IFU_PERF_EN
    output logic [31:0]       perf_fetch_count,
    output logic [31:0]       perf_stall_count,
`endif
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [EW-1:0]     head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              issue;

    // Handshake and issue decision; redirect suppresses any push.
    always_comb begin
        inst_valid    = ~fifo_empty;
        pop           = inst_valid & inst_ready;
        issue         = fetch_en & ~redirect_valid & (~fifo_full | pop);
        fetch_address = fetch_pc;
        inst_pc       = head[EW-1 -: ADDR_W];
        inst_data     = head[DATA_W-1:0];
    end

    // Fetch PC: redirect wins, otherwise advance by one word per issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_pc;
        else if (issue)          fetch_pc <= fetch_pc + 1'b1;
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .push    (issue),
        .pop     (pop),
        .wdata   ({fetch_pc, fetch_out}),
        .rdata   (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

`ifdef IFU_PERF_EN
    // Saturating counters: pushes, and cycles where decode holds off a valid head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_count <= '0;
            perf_stall_count <= '0;
        end else begin
            if (issue && perf_fetch_count != '1)
                perf_fetch_count <= perf_fetch_count + 1'b1;
            if (inst_valid && !inst_ready && perf_stall_count != '1)
                perf_stall_count <= perf_stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a combinational RAM model.
// Build with IFU_PERF_EN defined to also exercise the performance counters.
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] fetch_address;
    logic [DATA_W-1:0] fetch_out;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
`ifdef IFU_PERF_EN
    logic [31:0]       perf_fetch_count;
    logic [31:0]       perf_stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_address  (fetch_address),
        .fetch_out      (fetch_out),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
`ifdef IFU_PERF_EN
        .perf_fetch_count (perf_fetch_count),
        .perf_stall_count (perf_stall_count),
`endif
        .inst_pc        (inst_pc)
    );

    // RAM model: mem[i] = 1000_0000 + i, mem[7FFF] = DEAD_BEEF.
    always_comb begin
        if (fetch_address == 15'h7FFF) fetch_out = 32'hDEAD_BEEF;
        else                           fetch_out = 32'h1000_0000 + 32'(fetch_address);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        checks++; if (fetch_address !== 15'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", fetch_address); end
        checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", inst_data); end
        checks++; if (inst_pc !== 15'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", inst_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        reset_n    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, inst_valid); end
            checks++; if (inst_pc !== 15'(i)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, inst_pc, 15'(i)); end
            checks++; if (inst_data !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, inst_data, 32'h1000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1;
        reset_n  = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (inst_pc !== 15'h0 || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_head[%0d] got v=%0b pc=%h want v=1 pc=0000", i, inst_valid, inst_pc); end
            checks++; if (fetch_address !== 15'h2) begin errors++; $display("FAIL stall_addr[%0d] got %h want 0002", i, fetch_address); end
        end
`ifdef IFU_PERF_EN
        checks++; if (perf_stall_count !== 32'd5) begin errors++; $display("FAIL perf_stall got %0d want 5", perf_stall_count); end
`endif
        inst_ready = 1'b1;
        checks++; if (inst_pc !== 15'h0) begin errors++; $display("FAIL drain_pc[0] got %h want 0000", inst_pc); end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 15'(i)) begin errors++; $display("FAIL drain_pc[%0d] got v=%0b pc=%h want v=1 pc=%h", i, inst_valid, inst_pc, 15'(i)); end
            checks++; if (inst_data !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, inst_data, 32'h1000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1;
        reset_n  = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 15'h5;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %0b want 0", inst_valid); end
        checks++; if (fetch_address !== 15'h5) begin errors++; $display("FAIL redir_addr got %h want 0005", fetch_address); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 15'h5) begin errors++; $display("FAIL redir_pc got v=%0b pc=%h want v=1 pc=0005", inst_valid, inst_pc); end
        checks++; if (inst_data !== 32'h1000_0005) begin errors++; $display("FAIL redir_data got %h want 10000005", inst_data); end
        step();
        checks++; if (inst_pc !== 15'h6) begin errors++; $display("FAIL redir_next got %h want 0006", inst_pc); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 15'h7FFF;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_bubble got %0b want 0", inst_valid); end
        step();
        checks++; if (inst_pc !== 15'h7FFF || inst_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wrap_top got pc=%h d=%h want 7fff deadbeef", inst_pc, inst_data); end
        step();
        checks++; if (inst_pc !== 15'h0 || inst_data !== 32'h1000_0000) begin errors++; $display("FAIL wrap_zero got pc=%h d=%h want 0000 10000000", inst_pc, inst_data); end
    endtask

    task automatic test_fetch_disable();
        do_reset();
        fetch_en = 1'b1;
        reset_n  = 1'b1;
        step();
        step();
        fetch_en   = 1'b0;
        inst_ready = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 15'h1) begin errors++; $display("FAIL dis_second got v=%0b pc=%h want v=1 pc=0001", inst_valid, inst_pc); end
        step();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL dis_empty got %0b want 0", inst_valid); end
        step();
        checks++; if (fetch_address !== 15'h2 || inst_valid !== 1'b0) begin errors++; $display("FAIL dis_frozen got addr=%h v=%0b want 0002 0", fetch_address, inst_valid); end
    endtask

    task automatic test_async_reset();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (fetch_address === 15'h0) begin errors++; $display("FAIL prereset_addr got %h want nonzero", fetch_address); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", inst_valid); end
        checks++; if (fetch_address !== 15'h0) begin errors++; $display("FAIL areset_addr got %h want 0000", fetch_address); end
`ifdef IFU_PERF_EN
        checks++; if (perf_fetch_count !== 32'd0 || perf_stall_count !== 32'd0) begin errors++; $display("FAIL areset_perf got f=%0d s=%0d want 0 0", perf_fetch_count, perf_stall_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_disable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
